// File: rtl/pe_alu_pkg.sv
// Opcode encoding and the result/flag record shared by the PE ALU pipeline.
package pe_alu_pkg;
   localparam int OP_W  = 3;
   localparam int MAX_W = 64;

   typedef enum logic [OP_W-1:0] {
      OP_OR  = 3'd0,
      OP_XOR = 3'd1,
      OP_ADD = 3'd2,
      OP_SUB = 3'd3,
      OP_MUL = 3'd4,
      OP_MUX = 3'd5
   } op_e;

   // y is sized for the widest legal configuration; unused upper bits stay zero
   typedef struct packed {
      logic [MAX_W-1:0] y;
      logic             zero;
      logic             carry;
      logic             illegal;
   } alu_res_t;
endpackage

// File: rtl/pe_alu_comb.sv
// Combinational op/flag evaluation feeding the first pipeline stage.
module pe_alu_comb
   import pe_alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit MUL_SIGNED = 1'b0
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output alu_res_t         res
);
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   y;
   logic               carry;
   logic               illegal;
   logic               unused_mul_hi;

   assign sum  = {1'b0, a} + {1'b0, b};
   // Top bit of the widened difference is the unsigned borrow (a < b)
   assign diff = {1'b0, a} - {1'b0, b};

   generate
      if (MUL_SIGNED) begin : g_mul_s
         logic signed [2*WIDTH-1:0] a_x;
         logic signed [2*WIDTH-1:0] b_x;
         assign a_x  = {{WIDTH{a[WIDTH-1]}}, a};
         assign b_x  = {{WIDTH{b[WIDTH-1]}}, b};
         assign prod = a_x * b_x;
      end else begin : g_mul_u
         assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      end
   endgenerate

   assign unused_mul_hi = ^prod[2*WIDTH-1:WIDTH];

   always_comb begin
      y       = '0;
      carry   = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_ADD: begin
            y     = sum[WIDTH-1:0];
            carry = sum[WIDTH];
         end
         OP_SUB: begin
            y     = diff[WIDTH-1:0];
            carry = diff[WIDTH];
         end
         OP_MUL: y = prod[WIDTH-1:0];
         OP_MUX: y = s ? b : a;
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      res              = '0;
      res.y[WIDTH-1:0] = y;
      res.zero         = (y == '0);
      res.carry        = carry;
      res.illegal      = illegal;
   end
endmodule

// File: rtl/pe_alu_pipe.sv
// Pipelined PE ALU: op evaluation at the input, STAGES result registers,
// valid/ready on both sides with whole-pipe stall on back-pressure.
module pe_alu_pipe
   import pe_alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int STAGES     = 2,
   parameter bit MUL_SIGNED = 1'b0
) (
   input  logic             UserCLK,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             s_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y_o,
   output logic             zero_o,
   output logic             carry_o,
   output logic             illegal_o,
   output logic             busy_o
);
   alu_res_t                res_c;
   alu_res_t [STAGES-1:0]   res_p;
   logic     [STAGES-1:0]   vld_p;
   logic                    en;
   logic                    unused_y_hi;

   pe_alu_comb #(
      .WIDTH      (WIDTH),
      .MUL_SIGNED (MUL_SIGNED)
   ) u_comb (
      .op  (op_i),
      .a   (a_i),
      .b   (b_i),
      .s   (s_i),
      .res (res_c)
   );

   // Every stage advances together; only a held last stage can stall the pipe
   assign en       = !vld_p[STAGES-1] || out_ready;
   assign in_ready = en;

   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         vld_p <= '0;
         res_p <= '0;
      end else if (en) begin
         // stage 0 captures the freshly evaluated result, later stages shift
         vld_p[0] <= in_valid;
         res_p[0] <= res_c;
         for (int k = 1; k < STAGES; k++) begin
            vld_p[k] <= vld_p[k-1];
            res_p[k] <= res_p[k-1];
         end
      end
   end

   // output stage
   assign out_valid   = vld_p[STAGES-1];
   assign y_o         = res_p[STAGES-1].y[WIDTH-1:0];
   assign zero_o      = res_p[STAGES-1].zero;
   assign carry_o     = res_p[STAGES-1].carry;
   assign illegal_o   = res_p[STAGES-1].illegal;
   assign busy_o      = |vld_p;
   assign unused_y_hi = ^(res_p[STAGES-1].y >> WIDTH);
endmodule

// File: tb/tb_pe_alu_pipe.sv
// Scoreboard bench for pe_alu_pipe: expected beats queued at accept,
// compared in order as the pipe emits them.
module tb_pe_alu_pipe;
   localparam int W      = 32;
   localparam int STAGES = 2;

   typedef struct packed {
      logic [W-1:0] y;
      logic         z;
      logic         c;
      logic         i;
   } exp_t;

   logic         UserCLK = 1'b0;
   logic         resetn  = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op_i = '0;
   logic [W-1:0] a_i  = '0;
   logic [W-1:0] b_i  = '0;
   logic         s_i  = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] y_o;
   logic         zero_o;
   logic         carry_o;
   logic         illegal_o;
   logic         busy_o;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   bp_rand = 1'b0;

   pe_alu_pipe #(
      .WIDTH      (W),
      .STAGES     (STAGES),
      .MUL_SIGNED (1'b0)
   ) dut (
      .UserCLK   (UserCLK),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_i      (op_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .s_i       (s_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_o       (y_o),
      .zero_o    (zero_o),
      .carry_o   (carry_o),
      .illegal_o (illegal_o),
      .busy_o    (busy_o)
   );

   always #5 UserCLK = ~UserCLK;

   always @(posedge UserCLK) begin
      if (bp_rand) begin
         #2;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Output side of the scoreboard
   always @(negedge UserCLK) begin
      exp_t got;
      exp_t e;
      if (resetn && out_valid && out_ready) begin
         got = {y_o, zero_o, carry_o, illegal_o};
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL beat: unexpected output y=%h z=%b c=%b i=%b, required no beat", y_o, zero_o, carry_o, illegal_o);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               n_err++;
               $display("FAIL beat: got y=%h z=%b c=%b i=%b, required y=%h z=%b c=%b i=%b",
                        got.y, got.z, got.c, got.i, e.y, e.z, e.c, e.i);
            end
         end
      end
   end

   function automatic exp_t mk(input logic [W-1:0] y, input logic z, input logic c, input logic i);
      mk = {y, z, c, i};
   endfunction

   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t        e;
      logic [W:0]  w;
      e = '0;
      case (op)
         3'd0: e.y = a | b;
         3'd1: e.y = a ^ b;
         3'd2: begin w = {1'b0, a} + {1'b0, b}; e.y = w[W-1:0]; e.c = w[W]; end
         3'd3: begin e.y = a - b; e.c = (a < b); end
         3'd4: e.y = a * b;
         3'd5: e.y = s ? b : a;
         default: e.i = 1'b1;
      endcase
      e.z = (e.y == '0);
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 3))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   // Presents one beat, waits for it to be taken, then queues its expectation
   task automatic drive_beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s, input exp_t e);
      int guard = 0;
      op_i = op; a_i = a; b_i = b; s_i = s; in_valid = 1'b1;
      @(negedge UserCLK);
      while (!in_ready && guard < 50) begin
         @(negedge UserCLK);
         guard++;
      end
      if (!in_ready) begin
         n_cmp++; n_err++;
         $display("FAIL accept: in_ready=%b after %0d cycles, required 1", in_ready, guard);
         in_valid = 1'b0;
      end else begin
         @(posedge UserCLK); #1;
         in_valid = 1'b0;
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain(input string tag);
      int guard = 0;
      while ((sb.size() != 0 || busy_o) && guard < 100) begin
         @(posedge UserCLK); #1;
         guard++;
      end
      n_cmp++;
      if (sb.size() != 0 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL %s_drain: pending=%0d busy=%b, required 0 0", tag, sb.size(), busy_o);
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge UserCLK);
      #1;
      n_cmp++;
      if ({out_valid, busy_o, zero_o, carry_o, illegal_o} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_flags: vld=%b busy=%b z=%b c=%b i=%b, required all 0",
                  out_valid, busy_o, zero_o, carry_o, illegal_o);
      end
      n_cmp++;
      if (y_o !== '0) begin n_err++; $display("FAIL reset_y: y=%h, required 0", y_o); end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: in_ready=%b, required 1", in_ready); end
      resetn = 1'b1;
      @(posedge UserCLK); #1;
   endtask

   task automatic test_latency;
      out_ready = 1'b1;
      drive_beat(3'd2, 32'd5, 32'd7, 1'b0, mk(32'd12, 1'b0, 1'b0, 1'b0));
      n_cmp++;
      if (out_valid !== 1'b0 || busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL lat_c1: out_valid=%b busy=%b, required 0 1", out_valid, busy_o);
      end
      @(posedge UserCLK); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || busy_o !== 1'b1 || y_o !== 32'd12 || zero_o !== 1'b0 || carry_o !== 1'b0) begin
         n_err++;
         $display("FAIL lat_c2: out_valid=%b busy=%b y=%h z=%b c=%b, required 1 1 0000000c 0 0",
                  out_valid, busy_o, y_o, zero_o, carry_o);
      end
      @(posedge UserCLK); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL lat_c3: out_valid=%b busy=%b, required 0 0", out_valid, busy_o);
      end
   endtask

   task automatic test_streaming;
      out_ready = 1'b1;
      drive_beat(3'd0, 32'hF0, 32'h0F, 1'b0, mk(32'hFF, 1'b0, 1'b0, 1'b0));
      drive_beat(3'd1, 32'hFF, 32'hFF, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b0));
      drive_beat(3'd3, 32'd3, 32'd5, 1'b0, mk(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0));
      drive_beat(3'd4, 32'h1_0000, 32'h1_0000, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b0));
      drive_beat(3'd5, 32'd1, 32'd2, 1'b1, mk(32'd2, 1'b0, 1'b0, 1'b0));
      repeat (STAGES) @(posedge UserCLK);
      #1;
      n_cmp++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stream_rate: pending=%0d out_valid=%b, required 0 0", sb.size(), out_valid);
      end
   endtask

   task automatic test_back_pressure;
      logic [W-1:0] held;
      out_ready = 1'b0;
      drive_beat(3'd2, 32'd1, 32'd1, 1'b0, mk(32'd2, 1'b0, 1'b0, 1'b0));
      drive_beat(3'd1, 32'hA5, 32'h0F, 1'b0, mk(32'hAA, 1'b0, 1'b0, 1'b0));
      op_i = 3'd0; a_i = 32'h100; b_i = 32'h1; s_i = 1'b0; in_valid = 1'b1;
      held = y_o;
      n_cmp++;
      if (held !== 32'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_full: y=%h out_valid=%b in_ready=%b, required 00000002 1 0", held, out_valid, in_ready);
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge UserCLK); #1;
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || y_o !== held) begin
            n_err++;
            $display("FAIL bp_stall: cyc=%0d in_ready=%b out_valid=%b y=%h, required 0 1 %h",
                     c, in_ready, out_valid, y_o, held);
         end
      end
      out_ready = 1'b1;
      @(negedge UserCLK);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: in_ready=%b, required 1", in_ready);
         in_valid = 1'b0;
      end else begin
         @(posedge UserCLK); #1;
         in_valid = 1'b0;
         sb.push_back(mk(32'h101, 1'b0, 1'b0, 1'b0));
      end
      wait_drain("bp");
   endtask

   task automatic test_carry_edge;
      out_ready = 1'b1;
      drive_beat(3'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, mk(32'h0, 1'b1, 1'b1, 1'b0));
      drive_beat(3'd3, 32'd0, 32'd0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b0));
      drive_beat(3'd2, 32'h8000_0000, 32'h8000_0000, 1'b0, mk(32'h0, 1'b1, 1'b1, 1'b0));
      drive_beat(3'd3, 32'd5, 32'd3, 1'b0, mk(32'd2, 1'b0, 1'b0, 1'b0));
      wait_drain("carry");
   endtask

   task automatic test_illegal;
      out_ready = 1'b1;
      drive_beat(3'd7, 32'd9, 32'd9, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL ill_early: out_valid=%b, required 0", out_valid); end
      @(posedge UserCLK); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || illegal_o !== 1'b1 || y_o !== '0 || zero_o !== 1'b1 || carry_o !== 1'b0) begin
         n_err++;
         $display("FAIL ill_lat: out_valid=%b i=%b y=%h z=%b c=%b, required 1 1 00000000 1 0",
                  out_valid, illegal_o, y_o, zero_o, carry_o);
      end
      drive_beat(3'd6, 32'hFFFF_FFFF, 32'd1, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1));
      wait_drain("illegal");
   endtask

   task automatic test_random;
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      bp_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         s  = 1'($urandom_range(0, 1));
         drive_beat(op, a, b, s, model(op, a, b, s));
      end
      bp_rand = 1'b0;
      @(posedge UserCLK); #3;
      out_ready = 1'b1;
      wait_drain("rand");
   endtask

   task automatic test_midflight_reset;
      out_ready = 1'b1;
      drive_beat(3'd2, 32'd1, 32'd2, 1'b0, mk(32'd3, 1'b0, 1'b0, 1'b0));
      drive_beat(3'd0, 32'd4, 32'd8, 1'b0, mk(32'hC, 1'b0, 1'b0, 1'b0));
      n_cmp++;
      if (busy_o !== 1'b1 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL mr_pre: busy=%b out_valid=%b, required 1 1", busy_o, out_valid);
      end
      #1 resetn = 1'b0;
      #1;
      sb.delete();
      n_cmp++;
      if (out_valid !== 1'b0 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL mr_async: out_valid=%b busy=%b, required 0 0", out_valid, busy_o);
      end
      @(posedge UserCLK); #1;
      resetn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge UserCLK); #1;
         n_cmp++;
         if (out_valid !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL mr_stale: cyc=%0d out_valid=%b busy=%b, required 0 0", c, out_valid, busy_o);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_latency();
      test_streaming();
      test_back_pressure();
      test_carry_edge();
      test_illegal();
      test_random();
      test_midflight_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
